mux8_rr_arbiter: RTL

//  Round-robin arbiter sharing one 8-to-1 mux output path among 8 requesters.

---
 rtl/mux8_rr_arbiter.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/mux8_rr_arbiter.sv
// +----------------------------------------------------------------------------+
// | Module      : mux8_rr_arbiter                                              |
// | Description : Round-robin arbiter driving the select and one-hot grant of  |
// |               an 8:1 mux. Optional hold-time limit enabled by the macro    |
// |               ARB_TIMEOUT_EN (HOLD_MAX cycles).                            |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
`default_nettype none

module mux8_rr_arbiter #(
  parameter int HOLD_MAX = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] req,
  input  logic       done,
  output logic [2:0] sel,
  output logic [7:0] gnt,
  output logic       valid,
  output logic       timeout
);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_t;

  state_t     r_state;
  state_t     w_state_nxt;
  logic [2:0] r_sel;
  logic [2:0] w_sel_nxt;
  logic [7:0] r_gnt;
  logic [7:0] w_gnt_nxt;
  logic       r_valid;
  logic       w_valid_nxt;
  logic       r_timeout;
  logic       w_timeout_nxt;
  logic [2:0] r_ptr;
  logic [2:0] w_ptr_nxt;

  logic       w_found;
  logic [2:0] w_pick;
  logic       w_release;
  logic       w_limit;

  // Walk offsets from high to low so the smallest offset from ptr wins.
  always_comb begin
    w_found = 1'b0;
    w_pick  = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (req[r_ptr + 3'(i)]) begin
        w_found = 1'b1;
        w_pick  = r_ptr + 3'(i);
      end
    end
  end

  assign w_release = done | ~req[r_sel];

`ifdef ARB_TIMEOUT_EN
  localparam int              CNT_W    = (HOLD_MAX > 2) ? $clog2(HOLD_MAX) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HOLD_MAX - 1);

  logic [CNT_W-1:0] r_hold_cnt;
  logic [CNT_W-1:0] w_hold_cnt_nxt;

  // Counts cycles spent in GRANT; zero on the first grant cycle.
  assign w_hold_cnt_nxt = (r_state == ST_GRANT) ? r_hold_cnt + CNT_W'(1) : '0;
  assign w_limit        = (r_state == ST_GRANT) && (r_hold_cnt == CNT_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hold_cnt <= '0;
    end else begin
      r_hold_cnt <= w_hold_cnt_nxt;
    end
  end
`else
  logic [31:0] unused_hold_max;
  assign unused_hold_max = 32'(HOLD_MAX);
  assign w_limit         = 1'b0;
`endif

  always_comb begin
    w_state_nxt   = r_state;
    w_sel_nxt     = r_sel;
    w_gnt_nxt     = r_gnt;
    w_valid_nxt   = r_valid;
    w_timeout_nxt = 1'b0;
    w_ptr_nxt     = r_ptr;
    case (r_state)
      ST_IDLE: begin
        w_gnt_nxt   = 8'd0;
        w_valid_nxt = 1'b0;
        if (w_found) begin
          w_state_nxt = ST_GRANT;
          w_sel_nxt   = w_pick;
          w_gnt_nxt   = 8'd1 << w_pick;
          w_valid_nxt = 1'b1;
          w_ptr_nxt   = w_pick + 3'd1;
        end
      end
      ST_GRANT: begin
        // A normal release takes precedence over the hold limit.
        if (w_release || w_limit) begin
          w_state_nxt   = ST_IDLE;
          w_gnt_nxt     = 8'd0;
          w_valid_nxt   = 1'b0;
          w_timeout_nxt = w_limit & ~w_release;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_gnt_nxt   = 8'd0;
        w_valid_nxt = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_sel     <= 3'd0;
      r_gnt     <= 8'd0;
      r_valid   <= 1'b0;
      r_timeout <= 1'b0;
      r_ptr     <= 3'd0;
    end else begin
      r_state   <= w_state_nxt;
      r_sel     <= w_sel_nxt;
      r_gnt     <= w_gnt_nxt;
      r_valid   <= w_valid_nxt;
      r_timeout <= w_timeout_nxt;
      r_ptr     <= w_ptr_nxt;
    end
  end

  assign sel     = r_sel;
  assign gnt     = r_gnt;
  assign valid   = r_valid;
  assign timeout = r_timeout;

endmodule

`default_nettype wire
